// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache: serves fetch-stage reads and fills misses from the memory controller.
// Latency: hit returns data combinationally in the request cycle; miss costs one lookup cycle plus memory cycles, then hits.
// Backpressure: while a fill is outstanding the datapath sees ihit=0 and its request is ignored until the fill retires.
module icache_2way #(
   parameter int SETS = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic [31:0] imemload,
   output logic        ihit,
   input  logic        iflush,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);
   localparam int WAYS = 2;
   localparam int IW   = $clog2(SETS);
   localparam int TW   = 32 - IW - 2;

   typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [29:0]     maddr_q, maddr_d;   // word address of the outstanding fill
   logic            drop_q, drop_d;     // flush seen mid-fill: discard the returning word
   logic [WAYS-1:0] valid_q [SETS];
   logic [TW-1:0]   tag_q   [SETS][WAYS];
   logic [31:0]     data_q  [SETS][WAYS];
   logic [SETS-1:0] lru_q;              // way to evict next in each set

   logic [IW-1:0]   idx, midx;
   logic [TW-1:0]   tag, mtag;
   logic            hit0, hit1;
   logic            victim;
   logic            fill_en;
   logic            touch_en;
   logic            touch_way;
   logic            unused_addr_bits;

   // Byte offset never selects anything in a word-wide cache.
   assign unused_addr_bits = ^imemaddr[1:0];

   assign idx  = imemaddr[IW+1:2];
   assign tag  = imemaddr[31:IW+2];
   assign midx = maddr_q[IW-1:0];
   assign mtag = maddr_q[29:IW];
   assign hit0 = valid_q[idx][0] && (tag_q[idx][0] == tag);
   assign hit1 = valid_q[idx][1] && (tag_q[idx][1] == tag);

   // Victim choice for the fill set: an empty way first, otherwise the LRU way.
   always_comb begin
      victim = lru_q[midx];
      if (!valid_q[midx][0]) begin
         victim = 1'b0;
      end else if (!valid_q[midx][1]) begin
         victim = 1'b1;
      end
   end

   // Lookup, miss entry and fill sequencing; outputs decoded from state.
   always_comb begin
      state_d   = state_q;
      maddr_d   = maddr_q;
      drop_d    = drop_q;
      ihit      = 1'b0;
      imemload  = 32'h0;
      iREN      = 1'b0;
      iaddr     = 32'h0;
      fill_en   = 1'b0;
      touch_en  = 1'b0;
      touch_way = 1'b0;
      case (state_q)
         IDLE: begin
            // A flush cycle neither hits nor starts a fill.
            if (imemREN && !iflush) begin
               if (hit0 || hit1) begin
                  ihit      = 1'b1;
                  touch_en  = 1'b1;
                  touch_way = !hit0;   // way 0 wins a double match
                  imemload  = hit0 ? data_q[idx][0] : data_q[idx][1];
               end else begin
                  maddr_d = imemaddr[31:2];
                  drop_d  = 1'b0;
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            iREN  = 1'b1;
            iaddr = {maddr_q, 2'b00};
            if (iflush) begin
               drop_d = 1'b1;
            end
            if (!iwait) begin
               state_d = IDLE;
               drop_d  = 1'b0;
               fill_en = !drop_q && !iflush;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, valid and LRU bits; flush overrides any same-cycle update.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         maddr_q <= '0;
         drop_q  <= 1'b0;
         lru_q   <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
         end
      end else begin
         state_q <= state_d;
         maddr_q <= maddr_d;
         drop_q  <= drop_d;
         if (iflush) begin
            lru_q <= '0;
            for (int s = 0; s < SETS; s++) begin
               valid_q[s] <= '0;
            end
         end else if (fill_en) begin
            valid_q[midx][victim] <= 1'b1;
            lru_q[midx]           <= ~victim;
         end else if (touch_en) begin
            lru_q[idx] <= ~touch_way;
         end
      end
   end

   // Tag and data storage: written only by a completed, undropped fill.
   always_ff @(posedge CLK) begin
      if (!RST && fill_en) begin
         tag_q[midx][victim]  <= mtag;
         data_q[midx][victim] <= iload;
      end
   end

endmodule

// File: tb/tb_icache_2way.sv
// Self-checking bench for icache_2way: directed scenarios plus randomized reads/flushes.
// Expected hit/miss and data come from a set/way/LRU model and a deterministic memory image.
// Memory wait states are driven per transaction; every wait is cycle-bounded.
module tb_icache_2way;
   logic        CLK;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        ihit;
   logic        iflush;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: per set, per way valid + tag; one LRU bit per set.
   bit          m_valid [8][2];
   logic [26:0] m_tag   [8][2];
   bit          m_lru   [8];

   icache_2way #(.SETS(8)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .imemload(imemload), .ihit(ihit), .iflush(iflush), .iREN(iREN),
      .iaddr(iaddr), .iwait(iwait), .iload(iload)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] memword(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h40) return 32'h8C010004;
      return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic int mdl_way(input logic [31:0] a);
      for (int w = 0; w < 2; w++) begin
         if (m_valid[a[4:2]][w] && m_tag[a[4:2]][w] == a[31:5]) return w;
      end
      return -1;
   endfunction

   task automatic mdl_access(input logic [31:0] a);
      int w;
      int v;
      w = mdl_way(a);
      if (w >= 0) begin
         m_lru[a[4:2]] = (w == 0);
      end else begin
         if (!m_valid[a[4:2]][0]) v = 0;
         else if (!m_valid[a[4:2]][1]) v = 1;
         else v = m_lru[a[4:2]] ? 1 : 0;
         m_valid[a[4:2]][v] = 1'b1;
         m_tag[a[4:2]][v]   = a[31:5];
         m_lru[a[4:2]]      = (v == 0);
      end
   endtask

   task automatic mdl_flush();
      for (int s = 0; s < 8; s++) begin
         m_valid[s][0] = 1'b0;
         m_valid[s][1] = 1'b0;
         m_lru[s]      = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0;
      iwait = 1'b1; iload = 32'h0;
      tick();
      tick();
      RST = 1'b0;
      mdl_flush();
   endtask

   // One complete read: lookup, optional fill with nwait stall cycles, final hit cycle.
   task automatic read_txn(input logic [31:0] addr, input int nwait,
                           output bit hit1, output bit hit2, output logic [31:0] dat,
                           output int ren_cyc, output int bad_iaddr);
      hit1 = 1'b0; hit2 = 1'b0; dat = 32'h0; ren_cyc = 0; bad_iaddr = 0;
      imemREN = 1'b1; imemaddr = addr; iflush = 1'b0; iwait = 1'b1; iload = 32'h0;
      #1;
      if (iREN) ren_cyc++;
      if (ihit) begin
         hit1 = 1'b1;
         dat  = imemload;
         tick();
         imemREN = 1'b0;
         mdl_access(addr);
         return;
      end
      tick();
      for (int k = 0; k < 64; k++) begin
         iwait = (k < nwait);
         iload = (k < nwait) ? 32'hDEADBEEF : memword(addr);
         #1;
         if (iREN) ren_cyc++;
         if (iaddr !== {addr[31:2], 2'b00}) bad_iaddr++;
         tick();
         if (k >= nwait) break;
      end
      iwait = 1'b1;
      #1;
      hit2 = ihit;
      dat  = imemload;
      tick();
      imemREN = 1'b0;
      mdl_access(addr);
   endtask

   task automatic test_reset();
      bit h1, h2; logic [31:0] d; int rc, bi;
      do_reset();
      #1;
      n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL reset_ihit got %0b want 0", ihit); end
      n_cmp++; if (imemload !== 32'h0) begin n_err++; $display("FAIL reset_imemload got %h want 0", imemload); end
      n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL reset_iREN got %0b want 0", iREN); end
      n_cmp++; if (iaddr !== 32'h0) begin n_err++; $display("FAIL reset_iaddr got %h want 0", iaddr); end
      tick();
      read_txn(32'h0000_0004, 0, h1, h2, d, rc, bi);
      n_cmp++; if (h1 !== 1'b0) begin n_err++; $display("FAIL reset_cold got hit=%0b want 0", h1); end
   endtask

   task automatic test_cold_miss();
      bit h1, h2; logic [31:0] d; int rc, bi;
      do_reset();
      read_txn(32'h0000_0040, 3, h1, h2, d, rc, bi);
      n_cmp++; if (h1 !== 1'b0) begin n_err++; $display("FAIL cold_first got hit=%0b want 0", h1); end
      n_cmp++; if (rc != 4) begin n_err++; $display("FAIL cold_iren_cycles got %0d want 4", rc); end
      n_cmp++; if (bi != 0) begin n_err++; $display("FAIL cold_iaddr got %0d bad cycles want 0", bi); end
      n_cmp++; if (h2 !== 1'b1 || d !== 32'h8C010004) begin
         n_err++; $display("FAIL cold_fill got hit=%0b data=%h want 1 8c010004", h2, d);
      end
   endtask

   task automatic test_conflict_lru();
      bit h1, h2; logic [31:0] d; int rc, bi;
      logic [31:0] seq [6];
      bit          exp [6];
      seq = '{32'h00, 32'h20, 32'h00, 32'h40, 32'h00, 32'h20};
      exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if ((mdl_way(seq[i]) >= 0) != exp[i]) begin
            n_err++; $display("FAIL lru_model step %0d got %0b want %0b", i, mdl_way(seq[i]) >= 0, exp[i]);
         end
         read_txn(seq[i], 1, h1, h2, d, rc, bi);
         n_cmp++;
         if (h1 !== exp[i] || d !== memword(seq[i])) begin
            n_err++; $display("FAIL lru_step%0d addr %h got hit=%0b data=%h want %0b %h",
                              i, seq[i], h1, d, exp[i], memword(seq[i]));
         end
      end
   endtask

   task automatic test_branch_mid_miss();
      bit h1, h2; logic [31:0] d; int rc, bi;
      do_reset();
      imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
      #1;
      n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL branch_miss got ihit=%0b want 0", ihit); end
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k == 1) imemaddr = 32'h100;
         iwait = (k < 3);
         iload = (k < 3) ? 32'hDEADBEEF : memword(32'h80);
         #1;
         n_cmp++;
         if (iREN !== 1'b1 || iaddr !== 32'h80) begin
            n_err++; $display("FAIL branch_iaddr cyc %0d got iREN=%0b iaddr=%h want 1 00000080", k, iREN, iaddr);
         end
         tick();
      end
      mdl_access(32'h80);
      iwait = 1'b1;
      #1;
      n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL branch_new_lookup got ihit=%0b want 0", ihit); end
      tick();
      iwait = 1'b0; iload = memword(32'h100);
      #1;
      n_cmp++; if (iaddr !== 32'h100) begin n_err++; $display("FAIL branch_refetch got iaddr=%h want 00000100", iaddr); end
      tick();
      iwait = 1'b1;
      #1;
      n_cmp++; if (ihit !== 1'b1 || imemload !== memword(32'h100)) begin
         n_err++; $display("FAIL branch_new_hit got %0b %h want 1 %h", ihit, imemload, memword(32'h100));
      end
      tick();
      imemREN = 1'b0;
      mdl_access(32'h100);
      read_txn(32'h80, 0, h1, h2, d, rc, bi);
      n_cmp++; if (h1 !== 1'b1 || d !== memword(32'h80)) begin
         n_err++; $display("FAIL branch_old_hit got %0b %h want 1 %h", h1, d, memword(32'h80));
      end
   endtask

   task automatic test_flush();
      bit h1, h2; logic [31:0] d; int rc, bi;
      logic [31:0] chk [3];
      chk = '{32'h0C, 32'h04, 32'h08};
      do_reset();
      read_txn(32'h04, 0, h1, h2, d, rc, bi);
      read_txn(32'h08, 2, h1, h2, d, rc, bi);
      // flush while the memory is still stalling
      imemREN = 1'b1; imemaddr = 32'h0C; iwait = 1'b1;
      #1; tick();
      iflush = 1'b1;
      #1; tick();
      iflush = 1'b0;
      mdl_flush();
      #1; tick();
      iwait = 1'b0; iload = memword(32'h0C);
      #1;
      n_cmp++; if (iREN !== 1'b1) begin n_err++; $display("FAIL flush_fetch_alive got iREN=%0b want 1", iREN); end
      tick();
      imemREN = 1'b0; iwait = 1'b1;
      #1;
      n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL flush_back_idle got iREN=%0b want 0", iREN); end
      for (int i = 0; i < 3; i++) begin
         read_txn(chk[i], 1, h1, h2, d, rc, bi);
         n_cmp++; if (h1 !== 1'b0) begin n_err++; $display("FAIL flush_dropped %h got hit=%0b want 0", chk[i], h1); end
      end
      // flush coinciding with the returning word
      imemREN = 1'b1; imemaddr = 32'h14;
      #1; tick();
      iwait = 1'b0; iflush = 1'b1; iload = memword(32'h14);
      #1; tick();
      iflush = 1'b0; iwait = 1'b1; imemREN = 1'b0;
      mdl_flush();
      read_txn(32'h14, 0, h1, h2, d, rc, bi);
      n_cmp++; if (h1 !== 1'b0) begin n_err++; $display("FAIL flush_same_cycle got hit=%0b want 0", h1); end
      // flush in IDLE over a resident line
      imemREN = 1'b1; imemaddr = 32'h14; iflush = 1'b1;
      #1;
      n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL flush_idle_hit got ihit=%0b want 0", ihit); end
      tick();
      iflush = 1'b0; imemREN = 1'b0;
      mdl_flush();
      #1;
      n_cmp++; if (iREN !== 1'b0) begin n_err++; $display("FAIL flush_idle_nomiss got iREN=%0b want 0", iREN); end
      read_txn(32'h14, 0, h1, h2, d, rc, bi);
      n_cmp++; if (h1 !== 1'b0) begin n_err++; $display("FAIL flush_idle_after got hit=%0b want 0", h1); end
   endtask

   task automatic test_reset_mid();
      bit h1, h2; logic [31:0] d; int rc, bi;
      do_reset();
      read_txn(32'h200, 0, h1, h2, d, rc, bi);
      imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
      #1; tick();
      #1;
      n_cmp++; if (iREN !== 1'b1) begin n_err++; $display("FAIL rstmid_fetch got iREN=%0b want 1", iREN); end
      RST = 1'b1; iwait = 1'b0; iload = memword(32'h300);
      tick();
      RST = 1'b0; imemREN = 1'b0; iwait = 1'b1;
      mdl_flush();
      #1;
      n_cmp++; if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
         n_err++; $display("FAIL rstmid_outputs got iREN=%0b iaddr=%h ihit=%0b want 0 0 0", iREN, iaddr, ihit);
      end
      read_txn(32'h200, 0, h1, h2, d, rc, bi);
      n_cmp++; if (h1 !== 1'b0) begin n_err++; $display("FAIL rstmid_prior_line got hit=%0b want 0", h1); end
      read_txn(32'h300, 0, h1, h2, d, rc, bi);
      n_cmp++; if (h1 !== 1'b0) begin n_err++; $display("FAIL rstmid_no_fill got hit=%0b want 0", h1); end
   endtask

   task automatic test_back_to_back();
      bit h1, h2; logic [31:0] d; int rc, bi;
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         read_txn(i * 4, $urandom_range(0, 2), h1, h2, d, rc, bi);
      end
      imemREN = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a = (i * 4) ^ ($urandom_range(0, 1) ? 32'h20 : 32'h0);
         imemaddr = a;
         #1;
         n_cmp++;
         if (ihit !== 1'b1 || imemload !== memword(a) || iREN !== 1'b0) begin
            n_err++; $display("FAIL b2b addr %h got ihit=%0b data=%h iREN=%0b want 1 %h 0",
                              a, ihit, imemload, iREN, memword(a));
         end
         tick();
         mdl_access(a);
      end
      imemREN = 1'b0;
   endtask

   task automatic test_random();
      bit h1, h2; logic [31:0] d; int rc, bi;
      logic [31:0] a;
      bit exp;
      int nw;
      do_reset();
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 19) == 0) begin
            imemREN = 1'($urandom_range(0, 1)); imemaddr = $urandom_range(0, 127); iflush = 1'b1;
            #1;
            n_cmp++; if (ihit !== 1'b0) begin n_err++; $display("FAIL rand_flush it %0d got ihit=%0b want 0", it, ihit); end
            tick();
            iflush = 1'b0; imemREN = 1'b0;
            mdl_flush();
         end else begin
            a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            nw = $urandom_range(0, 3);
            exp = (mdl_way(a) >= 0);
            read_txn(a, nw, h1, h2, d, rc, bi);
            n_cmp++;
            if (h1 !== exp || d !== memword(a)) begin
               n_err++; $display("FAIL rand_read it %0d addr %h got hit=%0b data=%h want %0b %h",
                                 it, a, h1, d, exp, memword(a));
            end
            if (!exp) begin
               n_cmp++;
               if (h2 !== 1'b1 || rc != nw + 1 || bi != 0) begin
                  n_err++; $display("FAIL rand_fill it %0d got hit=%0b iren=%0d badaddr=%0d want 1 %0d 0",
                                    it, h2, rc, bi, nw + 1);
               end
            end
         end
      end
   endtask

   initial begin
      RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0; iwait = 1'b1; iload = 32'h0;
      test_reset();
      test_cold_miss();
      test_conflict_lru();
      test_branch_mid_miss();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
